// File: rtl/rhs_spi_responder.sv
// RHS2116-style SPI responder: 32-bit command frames in, two-frame-pipelined results out on MISO.
// Optional RHS_SPI_STATS_EN adds frame_cnt/err_cnt commit and error counters.
module rhs_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_REGS    = 64,
    parameter logic [15:0] CHIP_ID     = 16'd32
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        CS_b,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        cmd_valid,
    output logic [31:0] cmd_word,
    output logic        reg_wr,
    output logic [7:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data,
`ifdef RHS_SPI_STATS_EN
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt,
`endif
    output logic        frame_err
);

    typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

    state_e            state;
    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
    logic [1:0]        cs_hist, sclk_hist;
    logic              mosi_hist;
    logic [31:0]       shift_reg, out_sr;
    logic [5:0]        bit_cnt;
    logic [31:0]       pipe0, pipe1;
    logic [9:0]        conv_cnt;
    logic [15:0]       regs [NUM_REGS];
    logic [7:0]        addr;
    logic [15:0]       rdata, ac;
    logic [31:0]       result;
    logic              wr_hit;
    logic              cs_fall, cs_rise, sclk_rise, sclk_fall;

    assign cs_fall   = cs_hist[1] & ~cs_hist[0];
    assign cs_rise   = ~cs_hist[1] & cs_hist[0];
    assign sclk_rise = ~sclk_hist[1] & sclk_hist[0];
    assign sclk_fall = sclk_hist[1] & ~sclk_hist[0];

    assign addr   = shift_reg[23:16];
    assign ac     = {conv_cnt, shift_reg[21:16]};
    assign wr_hit = (shift_reg[31:30] == 2'b10) && (32'(addr) < NUM_REGS);

    always_comb begin
        rdata = 16'h0000;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (addr == i[7:0]) rdata = regs[i];
        end
        case (addr)
            8'd251:  rdata = 16'h0049;
            8'd252:  rdata = 16'h004E;
            8'd253:  rdata = 16'h0054;
            8'd255:  rdata = CHIP_ID;
            default: ;
        endcase
    end

    always_comb begin
        case (shift_reg[31:30])
            2'b00:   result = {ac, ~ac};
            2'b10:   result = {16'hFFFF, shift_reg[15:0]};
            2'b11:   result = {16'h0000, rdata};
            default: result = 32'h0080_0000;
        endcase
    end

    // Sync flops reset low so a CS_b already low at reset release never opens a frame.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cs_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_hist   <= '0;
            sclk_hist <= '0;
            mosi_hist <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_b};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            cs_hist   <= {cs_hist[0], cs_sync[SYNC_STAGES-1]};
            sclk_hist <= {sclk_hist[0], sclk_sync[SYNC_STAGES-1]};
            mosi_hist <= mosi_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= StIdle;
            MISO        <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_word    <= '0;
            reg_wr      <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
            frame_err   <= 1'b0;
            shift_reg   <= '0;
            out_sr      <= '0;
            bit_cnt     <= '0;
            pipe0       <= '0;
            pipe1       <= '0;
            conv_cnt    <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
`ifdef RHS_SPI_STATS_EN
            frame_cnt   <= '0;
            err_cnt     <= '0;
`endif
        end else begin
            cmd_valid <= 1'b0;
            reg_wr    <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                StIdle: begin
                    MISO <= 1'b0;
                    if (cs_fall) begin
                        state   <= StShift;
                        MISO    <= pipe1[31];
                        out_sr  <= pipe1;
                        bit_cnt <= '0;
                    end
                end
                StShift: begin
                    // CS_b rise wins over any SCLK edge seen in the same cycle.
                    if (cs_rise) begin
                        state <= StCommit;
                        MISO  <= 1'b0;
                        if (bit_cnt == 6'd32) begin
                            cmd_valid <= 1'b1;
                            cmd_word  <= shift_reg;
                            pipe1     <= pipe0;
                            pipe0     <= result;
                            if (shift_reg[31:30] == 2'b00) conv_cnt <= conv_cnt + 10'd1;
                            if (wr_hit) begin
                                reg_wr      <= 1'b1;
                                reg_wr_addr <= addr;
                                reg_wr_data <= shift_reg[15:0];
                                for (int i = 0; i < int'(NUM_REGS); i++) begin
                                    if (addr == i[7:0]) regs[i] <= shift_reg[15:0];
                                end
                            end
`ifdef RHS_SPI_STATS_EN
                            frame_cnt <= frame_cnt + 16'd1;
`endif
                        end else begin
                            frame_err <= 1'b1;
`ifdef RHS_SPI_STATS_EN
                            err_cnt   <= err_cnt + 16'd1;
`endif
                        end
                    end else if (sclk_rise) begin
                        shift_reg <= {shift_reg[30:0], mosi_hist};
                        if (bit_cnt != 6'd33) bit_cnt <= bit_cnt + 6'd1;
                    end else if (sclk_fall && bit_cnt != 6'd0) begin
                        out_sr <= {out_sr[30:0], 1'b0};
                        MISO   <= out_sr[30];
                    end
                end
                StCommit: begin
                    state <= StIdle;
                    MISO  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
